inst_loader: RTL and testbench

Program-load stage directly upstream of the processor core. Accepts instruction halfwords over a valid/ready stream, packs them into 32-bit words, and writes them into a 16-entry instruction memory. The core fetches from that memory through an asynchronous read port. The core is held in reset (`cpu_rst`) until a load completes.

---
 rtl/proc_pkg.sv | 22 ++
 rtl/inst_loader_hw_packer.sv | 46 ++++
 rtl/inst_loader.sv | 139 +++++++++++++
 tb/tb_inst_loader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor-side definitions: instruction memory geometry, halt opcode
// field and the program-loader state encoding.
package proc_pkg;

    localparam int IMEM_DEPTH = 16;
    localparam int IW         = 32;

    // Opcode field of an instruction word and the halt opcode value.
    localparam int         OPC_MSB = 31;
    localparam int         OPC_LSB = 27;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_LO,
        S_LOAD_HI,
        S_WRITE,
        S_DONE,
        S_RUN
    } ld_state_e;

endpackage

// File: rtl/inst_loader_hw_packer.sv
// Halfword packer: assembles two 16-bit stream beats (low half first) into one
// instruction word and strobes word_valid as the high half is accepted.
module hw_packer #(
    parameter int IW = 32
) (
    input  logic            clk,
    input  logic            sys_rst_n,
    input  logic [IW/2-1:0] ld_data,
    input  logic            ld_valid,
    input  logic            lo_sel,
    input  logic            hi_sel,
    output logic            ld_ready,
    output logic [IW-1:0]   hold,
    output logic            word_valid
);

    logic [IW-1:0] hold_q;
    logic [IW-1:0] hold_d;
    logic          lo_xfer;
    logic          hi_xfer;

    always_comb begin
        ld_ready   = lo_sel | hi_sel;
        lo_xfer    = lo_sel & ld_valid;
        hi_xfer    = hi_sel & ld_valid;
        word_valid = hi_xfer;
        hold_d     = hold_q;
        if (lo_xfer) begin
            hold_d[IW/2-1:0] = ld_data;
        end
        if (hi_xfer) begin
            hold_d[IW-1:IW/2] = ld_data;
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign hold = hold_q;

endmodule

// File: rtl/inst_loader.sv
// Program loader: packs streamed halfwords into the instruction memory and holds
// the core in reset until a load completes. Define INST_LOADER_HALT_DETECT_EN to end a load early on a halt word.
module inst_loader #(
    parameter int DEPTH = proc_pkg::IMEM_DEPTH,
    parameter int IW    = proc_pkg::IW
) (
    input  logic                       clk,
    input  logic                       sys_rst_n,
    input  logic                       ld_start,
    input  logic [$clog2(DEPTH+1)-1:0] ld_len,
    input  logic [IW/2-1:0]            ld_data,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [$clog2(DEPTH)-1:0]   fetch_addr,
    output logic [IW-1:0]              fetch_inst,
    output logic                       cpu_rst,
    output logic                       ld_done,
    output logic                       ld_err,
    output logic [$clog2(DEPTH+1)-1:0] words_loaded
);
    import proc_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    ld_state_e        state_q, state_d;
    logic [LW-1:0]    len_q, len_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic             err_q, err_d;
    logic             mem_we;
    logic [DEPTH-1:0] ent_we;
    logic [IW-1:0]    mem_q [DEPTH];
    logic [IW-1:0]    hold;
    logic             word_valid;
    logic             halt_hit;
    logic             len_ok;
    logic             last_word;

    hw_packer #(.IW(IW)) u_packer (
        .clk        (clk),
        .sys_rst_n  (sys_rst_n),
        .ld_data    (ld_data),
        .ld_valid   (ld_valid),
        .lo_sel     (state_q == S_LOAD_LO),
        .hi_sel     (state_q == S_LOAD_HI),
        .ld_ready   (ld_ready),
        .hold       (hold),
        .word_valid (word_valid)
    );

`ifdef INST_LOADER_HALT_DETECT_EN
    assign halt_hit = (hold[OPC_MSB:OPC_LSB] == OP_HALT);
`else
    assign halt_hit = 1'b0;
`endif

    assign len_ok    = (ld_len != '0) && (ld_len <= LW'(DEPTH));
    assign last_word = ((cnt_q + LW'(1)) == len_q);

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        err_d    = err_q;
        mem_we   = 1'b0;
        cpu_rst  = 1'b1;
        ld_done  = 1'b0;
        case (state_q)
            S_IDLE, S_RUN: begin
                cpu_rst = (state_q != S_RUN);
                if (ld_start) begin
                    if (len_ok) begin
                        len_d    = ld_len;
                        cnt_d    = '0;
                        wr_ptr_d = '0;
                        err_d    = 1'b0;
                        state_d  = S_LOAD_LO;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD_LO: if (ld_valid) state_d = S_LOAD_HI;
            S_LOAD_HI: if (word_valid) state_d = S_WRITE;
            S_WRITE: begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
                cnt_d    = cnt_q + LW'(1);
                state_d  = (last_word || halt_hit) ? S_DONE : S_LOAD_LO;
            end
            S_DONE: begin
                ld_done = 1'b1;
                state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            err_q    <= err_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_we
            assign ent_we[gi] = mem_we && (wr_ptr_q == AW'(gi));
        end
    endgenerate

    // Memory is cleared by reset so a partial program never survives into RUN.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_we[i]) mem_q[i] <= hold;
            end
        end
    end

    assign fetch_inst   = mem_q[fetch_addr];
    assign ld_err       = err_q;
    assign words_loaded = cnt_q;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: vector tables for start/length handling,
// directed multi-cycle sequences and randomized loads against a word-level model.
`timescale 1ns/1ps
module tb_inst_loader;

    logic        clk        = 1'b0;
    logic        sys_rst_n  = 1'b0;
    logic        ld_start   = 1'b0;
    logic [4:0]  ld_len     = '0;
    logic [15:0] ld_data    = '0;
    logic        ld_valid   = 1'b0;
    logic [3:0]  fetch_addr = '0;
    logic        ld_ready;
    logic [31:0] fetch_inst;
    logic        cpu_rst;
    logic        ld_done;
    logic        ld_err;
    logic [4:0]  words_loaded;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wbuf      [16];
    logic [31:0] model_mem [16];

    typedef struct {
        logic       start;
        logic [4:0] len;
        logic       exp_err;
        logic       exp_ready;
        logic       exp_cpu_rst;
    } vec_t;

    vec_t idle_tbl [5];
    vec_t run_tbl  [3];

    always #5 clk = ~clk;

    inst_loader #(.DEPTH(16), .IW(32)) dut (
        .clk          (clk),
        .sys_rst_n    (sys_rst_n),
        .ld_start     (ld_start),
        .ld_len       (ld_len),
        .ld_data      (ld_data),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .fetch_addr   (fetch_addr),
        .fetch_inst   (fetch_inst),
        .cpu_rst      (cpu_rst),
        .ld_done      (ld_done),
        .ld_err       (ld_err),
        .words_loaded (words_loaded)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Words a load actually writes: len, or up to and including the first halt word.
    function automatic int exp_count(input int len);
        int n;
        n = len;
`ifdef INST_LOADER_HALT_DETECT_EN
        for (int i = len - 1; i >= 0; i--) begin
            if (wbuf[i][31:27] == 5'b11011) n = i + 1;
        end
`endif
        return n;
    endfunction

    task automatic check_mem(input string tag);
        for (int a = 0; a < 16; a++) begin
            fetch_addr = 4'(a);
            #1;
            check($sformatf("%s_mem%0d", tag, a), fetch_inst, model_mem[a]);
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outs(input string tag);
        check($sformatf("%s_cpu_rst", tag), 32'(cpu_rst), 32'd1);
        check($sformatf("%s_ready", tag), 32'(ld_ready), 32'd0);
        check($sformatf("%s_done", tag), 32'(ld_done), 32'd0);
        check($sformatf("%s_err", tag), 32'(ld_err), 32'd0);
        check($sformatf("%s_words", tag), 32'(words_loaded), 32'd0);
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        ld_start = v.start;
        ld_len   = v.len;
        step();
        ld_start = 1'b0;
        check($sformatf("%s_err", tag), 32'(ld_err), 32'(v.exp_err));
        check($sformatf("%s_ready", tag), 32'(ld_ready), 32'(v.exp_ready));
        check($sformatf("%s_cpu_rst", tag), 32'(cpu_rst), 32'(v.exp_cpu_rst));
    endtask

    // Streams wbuf into the DUT until ld_done (bounded) and checks the outcome.
    task automatic run_load(input int len, input bit do_start, input bit toggle, input string tag);
        int          half;
        int          cycles;
        int          cnt;
        logic [31:0] cur;
        bit          xfer;
        bit          in_write;
        cnt = exp_count(len);
        if (do_start) begin
            ld_start = 1'b1;
            ld_len   = 5'(len);
            step();
            ld_start = 1'b0;
            check($sformatf("%s_start_cpu_rst", tag), 32'(cpu_rst), 32'd1);
            check($sformatf("%s_start_ready", tag), 32'(ld_ready), 32'd1);
        end
        check($sformatf("%s_err_clr", tag), 32'(ld_err), 32'd0);
        half     = 0;
        cycles   = 0;
        in_write = 1'b0;
        while (!ld_done && cycles < 400) begin
            if (in_write) check($sformatf("%s_ready_wr%0d", tag, half / 2), 32'(ld_ready), 32'd0);
            ld_valid = toggle ? ((cycles % 2) == 0) : 1'b1;
            cur      = wbuf[(half >> 1) & 15];
            ld_data  = half[0] ? cur[31:16] : cur[15:0];
            xfer     = ld_valid && ld_ready;
            in_write = xfer && half[0];
            if (xfer) half++;
            step();
            cycles++;
        end
        ld_valid = 1'b0;
        check($sformatf("%s_done", tag), 32'(ld_done), 32'd1);
        check($sformatf("%s_words", tag), 32'(words_loaded), 32'(cnt));
        check($sformatf("%s_halves", tag), 32'(half), 32'(2 * cnt));
        if (!toggle) check($sformatf("%s_cycles", tag), 32'(cycles), 32'(3 * cnt));
        for (int i = 0; i < cnt; i++) model_mem[i] = wbuf[i];
        step();
        check($sformatf("%s_run_cpu_rst", tag), 32'(cpu_rst), 32'd0);
        check($sformatf("%s_run_done", tag), 32'(ld_done), 32'd0);
        check_mem(tag);
        $display("load %s: len=%0d toggle=%0d words=%0d cycles=%0d", tag, len, toggle, cnt, cycles);
    endtask

    initial begin
        int          pushed;
        int          guard;
        int          len;
        logic [31:0] w;

        idle_tbl[0] = '{1'b1, 5'd0,  1'b1, 1'b0, 1'b1};
        idle_tbl[1] = '{1'b0, 5'd9,  1'b1, 1'b0, 1'b1};
        idle_tbl[2] = '{1'b1, 5'd17, 1'b1, 1'b0, 1'b1};
        idle_tbl[3] = '{1'b1, 5'd31, 1'b1, 1'b0, 1'b1};
        idle_tbl[4] = '{1'b1, 5'd2,  1'b0, 1'b1, 1'b1};
        run_tbl[0]  = '{1'b1, 5'd0,  1'b1, 1'b0, 1'b0};
        run_tbl[1]  = '{1'b1, 5'd20, 1'b1, 1'b0, 1'b0};
        run_tbl[2]  = '{1'b0, 5'd1,  1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 16; i++) model_mem[i] = '0;

        // Power-on reset
        step();
        step();
        check_reset_outs("por");
        check_mem("por");
        sys_rst_n = 1'b1;
        step();
        check_reset_outs("por_rel");

        // Bad lengths in IDLE, then a valid start of the directed 2-word program
        for (int i = 0; i < 5; i++) apply_vec(idle_tbl[i], $sformatf("idle_v%0d", i));
        wbuf[0] = 32'h0840_0001;
        wbuf[1] = 32'h1084_0002;
        run_load(2, 1'b0, 1'b0, "dir2");

        // Bad lengths in RUN keep the core running; then a 1-word reload with a gappy stream
        for (int i = 0; i < 3; i++) apply_vec(run_tbl[i], $sformatf("run_v%0d", i));
        wbuf[0] = 32'hCAFE_1234;
        run_load(1, 1'b1, 1'b1, "tog1");

        // Halt opcode in the second word
        wbuf[0] = 32'h1111_1111;
        wbuf[1] = 32'hD800_0000;
        wbuf[2] = 32'h3333_3333;
        wbuf[3] = 32'h4444_4444;
        run_load(4, 1'b1, 1'b0, "halt");

        // Randomized loads, occasionally preceded by a rejected start
        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                ld_start = 1'b1;
                ld_len   = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(17, 31));
                step();
                ld_start = 1'b0;
                check($sformatf("rnd%0d_bad_err", it), 32'(ld_err), 32'd1);
                check($sformatf("rnd%0d_bad_cpu_rst", it), 32'(cpu_rst), 32'd0);
            end
            for (int i = 0; i < 16; i++) begin
                w = $urandom();
                if ($urandom_range(0, 9) == 0) w[31:27] = 5'b11011;
                wbuf[i] = w;
            end
            len = $urandom_range(1, 16);
            run_load(len, 1'b1, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", it));
        end

        // Asynchronous reset after three halfwords of a reload
        ld_start = 1'b1;
        ld_len   = 5'd4;
        step();
        ld_start = 1'b0;
        ld_valid = 1'b1;
        pushed   = 0;
        guard    = 0;
        while (pushed < 3 && guard < 20) begin
            ld_data = 16'hA5A0 + 16'(pushed);
            if (ld_ready) pushed++;
            step();
            guard++;
        end
        ld_valid = 1'b0;
        check("mid_pushed", 32'(pushed), 32'd3);
        sys_rst_n = 1'b0;
        #1;
        check_reset_outs("mid_rst");
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        check_mem("mid_rst");
        sys_rst_n = 1'b1;
        step();
        check_reset_outs("mid_rel");

        wbuf[0] = 32'h0000_0013;
        wbuf[1] = 32'h0010_0093;
        wbuf[2] = 32'h0020_8113;
        run_load(3, 1'b1, 1'b0, "post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
